// File: rtl/jtag_1149_d10_mstr_mc_status.sv
// ----------------------------------------------------------------------------
// jtag_1149_d10_mstr_mc_status
// Status collector for the master PEDDA channels. Each channel reports seven
// error levels. Every level is registered once (err_q) before use. Each level
// then sets a sticky bit. Each rising edge on any source counts as one event
// in a saturating per-channel counter. The first error seen is captured.
// A two-state clear FSM lets software clear one channel at a time.
//
// State table (clear FSM):
//   state   | meaning
//   ST_IDLE | waiting for clr_req; a request performs the clear at this edge
//   ST_ACK  | clr_ack high for this one cycle; clr_req is not sampled here
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   mstr_err_in           7 error levels per channel, channel c at [7c+6:7c]
//   irq_mask              per-source interrupt enable, shared by all channels
//   clr_req/clr_ch/clr_cnt   clear request, target channel, also clear counter
//   clr_ack               one-cycle clear acknowledge
//   dbg_ch_sel/dbg_mux_sel   debug channel and field select
//   dbg_mux_out           registered debug word
//   pedda_mst_status_out  per-channel OR of the sticky bits
//   mstr_irq              registered interrupt level
// ----------------------------------------------------------------------------
module jtag_1149_d10_mstr_mc_status #(
   parameter int NUM_CH         = 4,
   parameter int CH_IDX_WIDTH   = 2,
   parameter int ERR_CNTR_WIDTH = 16,
   parameter int DBG_OUT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7*NUM_CH-1:0]       mstr_err_in,
   input  logic [6:0]                irq_mask,
   input  logic                      clr_req,
   input  logic [CH_IDX_WIDTH-1:0]   clr_ch,
   input  logic                      clr_cnt,
   output logic                      clr_ack,
   input  logic [CH_IDX_WIDTH-1:0]   dbg_ch_sel,
   input  logic [1:0]                dbg_mux_sel,
   output logic [DBG_OUT_WIDTH-1:0]  dbg_mux_out,
   output logic [NUM_CH-1:0]         pedda_mst_status_out,
   output logic                      mstr_irq
);

   localparam int CW = (ERR_CNTR_WIDTH > DBG_OUT_WIDTH) ? ERR_CNTR_WIDTH : DBG_OUT_WIDTH;
   localparam logic [ERR_CNTR_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} clr_state_t;

   clr_state_t                 state, state_nxt;
   logic                       clr_fire;

   logic [7*NUM_CH-1:0]        err_q, err_qq;
   logic [6:0]                 err_ch   [NUM_CH];
   logic [6:0]                 new_set  [NUM_CH];
   logic [NUM_CH-1:0]          rise;
   logic [NUM_CH-1:0]          clr_sel;
   logic [6:0]                 sticky   [NUM_CH];
   logic [ERR_CNTR_WIDTH-1:0]  cnt      [NUM_CH];

   logic                       first_vld;
   logic [3:0]                 first_ch;
   logic [2:0]                 first_src;
   logic                       set_any, sticky_any, first_rearm;
   logic [3:0]                 cap_ch;
   logic [2:0]                 cap_src;
   logic                       irq_nxt;
   logic [DBG_OUT_WIDTH-1:0]   dbg_nxt;
   logic [CW-1:0]              cnt_w;

   // Clear FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr_fire  = 1'b0;
      clr_ack   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               clr_fire  = 1'b1;
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            clr_ack   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Per-channel decode. An out-of-range clr_ch matches no channel, so the
   // request is still acknowledged but changes nothing.
   always_comb begin
      set_any    = 1'b0;
      sticky_any = 1'b0;
      cap_ch     = '0;
      cap_src    = '0;
      irq_nxt    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         err_ch[c]               = err_q[7*c +: 7];
         new_set[c]              = err_ch[c] & ~sticky[c];
         rise[c]                 = |(err_ch[c] & ~err_qq[7*c +: 7]);
         clr_sel[c]              = clr_fire && (clr_ch == CH_IDX_WIDTH'(c));
         pedda_mst_status_out[c] = |sticky[c];
         sticky_any              = sticky_any | (|sticky[c]);
         irq_nxt                 = irq_nxt | (|(sticky[c] & irq_mask));
      end
      // Scan from the top down so the lowest channel and source win.
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (|new_set[c]) begin
            set_any = 1'b1;
            cap_ch  = 4'(c);
            for (int s = 6; s >= 0; s--) begin
               if (new_set[c][s]) cap_src = 3'(s);
            end
         end
      end
   end

   // The sticky register is already post-clear in the ACK cycle.
   assign first_rearm = clr_ack && !sticky_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q  <= '0;
         err_qq <= '0;
      end else begin
         err_q  <= mstr_err_in;
         err_qq <= err_q;
      end
   end

   // A set in the same cycle as a clear wins. A clear together with an event
   // leaves the counter at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sticky[c] <= '0;
            cnt[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            sticky[c] <= (clr_sel[c] ? 7'h00 : sticky[c]) | err_ch[c];
            if (clr_sel[c] && clr_cnt)
               cnt[c] <= rise[c] ? ERR_CNTR_WIDTH'(1) : '0;
            else if (rise[c] && (cnt[c] != CNT_MAX))
               cnt[c] <= cnt[c] + ERR_CNTR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_vld <= 1'b0;
         first_ch  <= '0;
         first_src <= '0;
      end else if (!first_vld || first_rearm) begin
         if (set_any) begin
            first_vld <= 1'b1;
            first_ch  <= cap_ch;
            first_src <= cap_src;
         end else if (first_rearm) begin
            first_vld <= 1'b0;
            first_ch  <= '0;
            first_src <= '0;
         end
      end
   end

   always_comb begin
      dbg_nxt = '0;
      cnt_w   = '0;
      if (dbg_mux_sel == 2'd3) begin
         dbg_nxt[7:0] = {first_vld, first_ch, first_src};
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (dbg_ch_sel == CH_IDX_WIDTH'(c)) begin
               case (dbg_mux_sel)
                  2'd0: dbg_nxt = DBG_OUT_WIDTH'(sticky[c]);
                  2'd1: begin
                     cnt_w   = CW'(cnt[c]);
                     dbg_nxt = cnt_w[DBG_OUT_WIDTH-1:0];
                  end
                  default: dbg_nxt = DBG_OUT_WIDTH'(err_ch[c]);
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_mux_out <= '0;
         mstr_irq    <= 1'b0;
      end else begin
         dbg_mux_out <= dbg_nxt;
         mstr_irq    <= irq_nxt;
      end
   end

endmodule

// File: doc/jtag_1149_d10_mstr_mc_status.md
JTAG_1149_D10_MSTR_MC_STATUS -- requirements
Module: jtag_1149_d10_mstr_mc_status

Interface
REQ-001 Parameter NUM_CH, default 4: number of master PEDDA channels monitored; legal 1..16.
REQ-002 Parameter CH_IDX_WIDTH, default 2: channel index width; SHALL satisfy 2**CH_IDX_WIDTH >= NUM_CH.
REQ-003 Parameter ERR_CNTR_WIDTH, default 16: per-channel error event counter width.
REQ-004 Parameter DBG_OUT_WIDTH, default 16: debug output width; legal >= 16.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mstr_err_in  input  7*NUM_CH  per-channel error levels; channel c uses bits [7c+6:7c], mapping per REQ-016.
REQ-008 irq_mask  input  7  per-source interrupt enable, common to all channels.
REQ-009 clr_req  input  1  clear request; held high until clr_ack.
REQ-010 clr_ch  input  CH_IDX_WIDTH  channel to clear; sampled with clr_req.
REQ-011 clr_cnt  input  1  when high with clr_req, the channel counter is also cleared.
REQ-012 clr_ack  output  1  one-cycle clear acknowledge.
REQ-013 dbg_ch_sel  input  CH_IDX_WIDTH  debug channel select.
REQ-014 dbg_mux_sel  input  2  debug field select.
REQ-015 dbg_mux_out  output  DBG_OUT_WIDTH  registered debug word; pedda_mst_status_out  output  NUM_CH  per-channel any-sticky flag; mstr_irq  output  1  interrupt level.

Function
REQ-016 Source bit mapping per channel: 0 opcode_error, 1 eop_error[0], 2 eop_error[1], 3 unrecoverable_error, 4 lpbk_error, 5 scan_rsp_time_out, 6 idle_count_error.
REQ-017 mstr_err_in SHALL be registered once (err_q) before use; err_q and its previous value (err_qq) form the edge detector; all behaviour below is relative to err_q.
REQ-018 Sticky[c][s] SHALL set in the cycle after err_q[c][s] is high and hold until cleared.
REQ-019 Event: for channel c, a cycle where any source has err_q=1 and err_qq=0; each event SHALL increment cnt[c] by exactly 1 regardless of how many sources rose.
REQ-020 cnt[c] SHALL saturate at 2**ERR_CNTR_WIDTH-1; no wrap-around.
REQ-021 Clear FSM states IDLE, ACK. IDLE: clr_req=1 -> clear sticky[clr_ch] (and cnt[clr_ch] if clr_cnt), go ACK, clr_ack=1 in that next cycle. ACK: return IDLE unconditionally; clr_req is not re-sampled in ACK.
REQ-022 Clear with clr_ch >= NUM_CH SHALL be acknowledged with no state change.
REQ-023 Clear and new set of the same sticky bit in the same cycle: set wins. Clear and event on the same counter in the same cycle: counter becomes 1.
REQ-024 First-error capture: first_vld, first_ch, first_src register the lowest-index channel and lowest-index source of the first cycle any sticky sets while first_vld=0; cleared only when all sticky bits of all channels are zero after a clear completes.
REQ-025 pedda_mst_status_out[c] = OR of sticky[c], combinational from registers.
REQ-026 mstr_irq SHALL be registered: high the cycle after any sticky[c][s] & irq_mask[s] is 1.
REQ-027 dbg_mux_out, one-cycle latency from selects, zero-extended to DBG_OUT_WIDTH: sel 0 -> sticky[dbg_ch_sel]; sel 1 -> cnt[dbg_ch_sel] (truncated to DBG_OUT_WIDTH LSBs if wider); sel 2 -> err_q[dbg_ch_sel]; sel 3 -> {first_vld, first_ch (4 bits, zero-padded), first_src (3 bits)} in bits [7:0].
REQ-028 dbg_ch_sel >= NUM_CH SHALL yield dbg_mux_out = 0 for sel 0-2; sel 3 ignores dbg_ch_sel.

Reset
REQ-029 On rst_n low, asynchronously: all sticky, cnt, err_q, err_qq, first_* = 0; FSM = IDLE; clr_ack, mstr_irq, dbg_mux_out, pedda_mst_status_out = 0.
REQ-030 Reset mid-clear SHALL abort the handshake; no clr_ack after release; pending clr_req is re-sampled from IDLE.

Verification
REQ-031 Ch2 bit5 pulses 1 cycle, irq_mask=7'h20 -> sticky[2]=7'h20, cnt[2]=1, status_out=4'b0100, mstr_irq=1, first = {1,2,5}.
REQ-032 Ch0 bits 0 and 3 rise same cycle, held 10 cycles -> cnt[0]=1; dbg sel0 ch0 -> 16'h0009.
REQ-033 ERR_CNTR_WIDTH=4, 20 separate events on ch1 -> cnt[1]=15, stays 15.
REQ-034 clr_req, clr_ch=2, clr_cnt=1 while ch2 bit5 re-rises same cycle -> clr_ack one cycle, sticky[2]=7'h20, cnt[2]=1.
REQ-035 clr_ch=5 with NUM_CH=4 -> clr_ack pulses, all state unchanged; dbg_ch_sel=5 sel1 -> 0.
REQ-036 rst_n low during ACK with sticky nonzero -> all outputs 0 immediately, clr_ack never asserts.
